// File: rtl/dispatch_credit_ctrl_if.sv
// Dispatch credit bus: dispatcher/ROB/RS/LSB events in, occupancy and stall status out.
interface dispatch_credit_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             rdy;
  logic             rollback_signal;
  logic             disp_fire;
  logic             disp_is_ls;
  logic             fet_valid;
  logic             rob_commit;
  logic             rs_release;
  logic             lsb_release;
  logic             lsb_store_commit;
  logic             lsb_release_is_cstore;
  logic             is_full;
  logic [CNT_W-1:0] rob_used;
  logic [CNT_W-1:0] rs_used;
  logic [CNT_W-1:0] lsb_used;
  logic [CNT_W-1:0] cstore_pend;
  logic [31:0]      stall_cycles;
  logic [1:0]       err;

  modport master (
    output rdy, rollback_signal, disp_fire, disp_is_ls, fet_valid, rob_commit,
           rs_release, lsb_release, lsb_store_commit, lsb_release_is_cstore,
    input  is_full, rob_used, rs_used, lsb_used, cstore_pend, stall_cycles, err
  );

  modport slave (
    input  rdy, rollback_signal, disp_fire, disp_is_ls, fet_valid, rob_commit,
           rs_release, lsb_release, lsb_store_commit, lsb_release_is_cstore,
    output is_full, rob_used, rs_used, lsb_used, cstore_pend, stall_cycles, err
  );
endinterface

// File: rtl/dispatch_credit_ctrl.sv
// Free-entry credit tracking for ROB/RS/LSB with a registered dispatch stall,
// rollback occupancy rebuild, stall-cycle counter and sticky protocol errors.
module dispatch_credit_ctrl #(
  parameter int ROB_SIZE = 16,
  parameter int RS_SIZE  = 16,
  parameter int LSB_SIZE = 16,
  parameter int CNT_W    = 5
) (
  input logic clk,
  input logic rst,
  dispatch_credit_ctrl_if.slave bus
);

  localparam logic [CNT_W:0] ROB_MAX = (CNT_W+1)'(ROB_SIZE);
  localparam logic [CNT_W:0] RS_MAX  = (CNT_W+1)'(RS_SIZE);
  localparam logic [CNT_W:0] LSB_MAX = (CNT_W+1)'(LSB_SIZE);

  logic [CNT_W-1:0] r_rob, r_rs, r_lsb, r_cs;
  logic             r_full;
  logic [31:0]      r_stall;
  logic [1:0]       r_err;

  logic [CNT_W-1:0] w_rob_nxt, w_rs_nxt, w_lsb_nxt, w_cs_nxt, w_cs_calc;
  logic             w_full_nxt, w_of, w_uf;
  logic             w_rs_inc, w_lsb_inc, w_cs_dec;

  // cur + inc - dec, floored at 0 and capped at size
  function automatic logic [CNT_W-1:0] upd(input logic [CNT_W-1:0] cur,
                                           input logic inc, input logic dec,
                                           input logic [CNT_W:0] size);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + {{CNT_W{1'b0}}, inc};
    if (dec && (sum != '0)) sum = sum - 1'b1;
    if (sum > size) sum = size;
    return sum[CNT_W-1:0];
  endfunction

  function automatic logic under(input logic [CNT_W-1:0] cur,
                                 input logic inc, input logic dec);
    return dec & ~inc & (cur == '0);
  endfunction

  always_comb begin
    w_rob_nxt  = r_rob;
    w_rs_nxt   = r_rs;
    w_lsb_nxt  = r_lsb;
    w_cs_nxt   = r_cs;
    w_of       = 1'b0;
    w_uf       = 1'b0;
    w_rs_inc   = bus.disp_fire & ~bus.disp_is_ls;
    w_lsb_inc  = bus.disp_fire & bus.disp_is_ls;
    w_cs_dec   = bus.lsb_release & bus.lsb_release_is_cstore;
    w_cs_calc  = upd(r_cs, bus.lsb_store_commit, w_cs_dec, LSB_MAX);
    if (bus.rollback_signal) begin
      // only committed stores survive a flush
      w_rob_nxt = '0;
      w_rs_nxt  = '0;
      w_lsb_nxt = w_cs_calc;
      w_cs_nxt  = w_cs_calc;
      w_uf      = under(r_cs, bus.lsb_store_commit, w_cs_dec);
    end else begin
      w_rob_nxt = upd(r_rob, bus.disp_fire, bus.rob_commit, ROB_MAX);
      w_rs_nxt  = upd(r_rs, w_rs_inc, bus.rs_release, RS_MAX);
      w_lsb_nxt = upd(r_lsb, w_lsb_inc, bus.lsb_release, LSB_MAX);
      w_cs_nxt  = (w_cs_calc > w_lsb_nxt) ? w_lsb_nxt : w_cs_calc;
      w_of      = bus.disp_fire & r_full;
      w_uf      = under(r_rob, bus.disp_fire, bus.rob_commit)
                | under(r_rs, w_rs_inc, bus.rs_release)
                | under(r_lsb, w_lsb_inc, bus.lsb_release)
                | under(r_cs, bus.lsb_store_commit, w_cs_dec);
    end
    w_full_nxt = ({1'b0, w_rob_nxt} == ROB_MAX) | ({1'b0, w_rs_nxt} == RS_MAX)
               | ({1'b0, w_lsb_nxt} == LSB_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rob   <= '0;
      r_rs    <= '0;
      r_lsb   <= '0;
      r_cs    <= '0;
      r_full  <= 1'b0;
      r_stall <= '0;
      r_err   <= '0;
    end else if (bus.rdy) begin
      r_rob   <= w_rob_nxt;
      r_rs    <= w_rs_nxt;
      r_lsb   <= w_lsb_nxt;
      r_cs    <= w_cs_nxt;
      r_full  <= w_full_nxt;
      r_err   <= r_err | {w_uf, w_of};
      if (bus.fet_valid && r_full) r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.is_full      = r_full;
  assign bus.rob_used     = r_rob;
  assign bus.rs_used      = r_rs;
  assign bus.lsb_used     = r_lsb;
  assign bus.cstore_pend  = r_cs;
  assign bus.stall_cycles = r_stall;
  assign bus.err          = r_err;

endmodule
